ps2_ascii_decoder: RTL and testbench
====================================

Name: ps2_ascii_decoder

Overview:
- Sits between the PS/2 keyboard interface and the LCD controller.
- Consumes the raw scan-code byte stream (one strobe per received byte) and tracks break (F0) and extended (E0) prefixes and shift state.
- Emits ASCII characters for key presses only, through a small first-word-fall-through FIFO with a valid/ready handshake.
- Replaces free-running combinational scan-code mapping, which repaints on break codes and cannot express shift.

Parameters:
- FIFO_DEPTH, 4: character buffer entries; power of two, at least 2.
- FIFO_AW, 2: log2(FIFO_DEPTH); must agree with FIFO_DEPTH.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- resetn  input  1  asynchronous active-low reset.
- ps2_key_pressed  input  1  one-cycle strobe; a new scan byte is valid on ps2_key_data.
- ps2_key_data  input  8  scan-code byte, sampled only when ps2_key_pressed=1.
- char_ready  input  1  consumer accepts char_data this cycle.
- char_valid  output  1  FIFO non-empty; char_data holds the oldest character.
- char_data  output  8  ASCII character at the FIFO head.
- shift_active  output  1  left or right shift is currently held.
- overflow  output  1  sticky; a character was dropped because the FIFO was full.

Behaviour:
- Reset (async, resetn=0):
  - FSM=IDLE; both shift flags=0.
  - FIFO empty; char_valid=0, char_data=8'h00, overflow=0, shift_active=0.
- Prefix FSM advances only on bytes where ps2_key_pressed=1:
  - IDLE: byte F0 -> BRK; E0 -> EXT; otherwise treat the byte as a make code, stay IDLE.
  - BRK: byte is a break code; apply it; -> IDLE.
  - EXT: F0 -> EXT_BRK; otherwise ignore the byte (extended make); -> IDLE.
  - EXT_BRK: ignore the byte; -> IDLE.
- Shift tracking:
  - Make 12 sets lshift; make 59 sets rshift.
  - Break 12 clears lshift; break 59 clears rshift.
  - shift_active = lshift | rshift, registered.
  - A shift make emits no character.
- Make-code map (unlisted codes emit nothing; break codes never emit):
  - Letters: 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z.
  - Letters use lowercase 8'h61-8'h7A; uppercase (subtract 8'h20) when shift_active.
  - Digits: 45 '0', 16 '1', 1E '2', 26 '3', 25 '4', 2E '5', 36 '6', 3D '7', 3E '8', 46 '9'. Shift does not affect digits.
  - 29 -> 8'h20 (space); 66 -> 8'h7F (delete); 5A -> 8'h0D (enter).
- Typematic repeats (make without intervening break) each emit a character.
- Latency: strobe at edge N with an emitting make -> entry written at edge N; char_valid=1 from cycle N+1 if the FIFO was empty.
- FIFO:
  - Pop on an edge where char_valid & char_ready.
  - Push and pop on the same edge: both occur; count unchanged, including when full.
  - Push when full with no pop: character dropped; overflow set, held until reset.
  - Pop when empty: ignored.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Reset mid-sequence (e.g. after F0) discards the pending prefix and all buffered characters.

Optional Feature:
- Macro: PS2_CAPSLOCK_EN.
- Defined:
  - Make 58 toggles a caps flag (typematic repeats of 58 toggle only once until break 58).
  - Letter case = shift_active XOR caps.
  - Extra output port caps_lock (1 bit, reset 0).
- Undefined: 58 is unmapped; no caps_lock port; letter case depends on shift only.

Decomposition:
- Package ps2_codes_pkg holds:
  - scan-code localparams: SC_BREAK=8'hF0, SC_EXT=8'hE0, SC_LSHIFT=8'h12, SC_RSHIFT=8'h59, SC_CAPS=8'h58, SC_ENTER=8'h5A, SC_BKSP=8'h66, SC_SPACE=8'h29;
  - the 2-bit FSM state encoding IDLE/BRK/EXT/EXT_BRK;
  - ASCII constants for delete, enter and space.
- Sub-module char_fifo: parameterised FWFT FIFO with push, din, pop, dout, empty, full.
- Decode FSM and map stay in the top module.

Test Plan:
- Reset release, then bytes 1C, F0, 1C -> exactly one char 8'h61; char_valid high one cycle after the 1C strobe; the break emits nothing.
- Bytes 12, 1C, F0, 1C, F0, 12, 1C with char_ready=1 -> chars 8'h41, then 8'h61; shift_active 1 between 12 and F0 12.
- Bytes E0, 75, E0, F0, 75, then 29 -> only 8'h20 emitted; FSM back in IDLE.
- char_ready=0, six make codes 16 1E 26 25 2E 36 -> char_valid=1, overflow=1, then drain gives 31 32 33 34 (depth 4); overflow stays 1.
- FIFO full, simultaneous pop and emitting make -> count stays 4, overflow stays 0, new char appears at the tail.
- resetn pulsed low asynchronously after F0 with 2 chars buffered -> char_valid=0 immediately; next byte 1C emits 8'h61.

Source files
------------

// File: rtl/ps2_codes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_codes_pkg
// Description : Shared definitions for the PS/2 scan-code decoder.
//               - scan-code constants (set 2)
//               - 2-bit prefix FSM state encoding
//               - ASCII constants for delete, enter and space
//               - map_make(): make code + case select -> {hit, ascii}
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_codes_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_SPACE  = 8'h29;

    localparam logic [7:0] ASCII_DEL   = 8'h7F;
    localparam logic [7:0] ASCII_ENTER = 8'h0D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    // Prefix state: which prefix bytes precede the next byte.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } ps2_state_e;

    // Returns {hit, ascii}. hit=0 means the make code produces no character.
    // upper only affects letters.
    function automatic logic [8:0] map_make(input logic [7:0] code,
                                            input logic       upper);
        logic [7:0] ch;
        logic       is_letter;
        logic       hit;
        ch        = 8'h00;
        is_letter = 1'b1;
        hit       = 1'b1;
        case (code)
            8'h1C: ch = 8'h61;  8'h32: ch = 8'h62;  8'h21: ch = 8'h63;
            8'h23: ch = 8'h64;  8'h24: ch = 8'h65;  8'h2B: ch = 8'h66;
            8'h34: ch = 8'h67;  8'h33: ch = 8'h68;  8'h43: ch = 8'h69;
            8'h3B: ch = 8'h6A;  8'h42: ch = 8'h6B;  8'h4B: ch = 8'h6C;
            8'h3A: ch = 8'h6D;  8'h31: ch = 8'h6E;  8'h44: ch = 8'h6F;
            8'h4D: ch = 8'h70;  8'h15: ch = 8'h71;  8'h2D: ch = 8'h72;
            8'h1B: ch = 8'h73;  8'h2C: ch = 8'h74;  8'h3C: ch = 8'h75;
            8'h2A: ch = 8'h76;  8'h1D: ch = 8'h77;  8'h22: ch = 8'h78;
            8'h35: ch = 8'h79;  8'h1A: ch = 8'h7A;
            default: is_letter = 1'b0;
        endcase
        if (!is_letter) begin
            case (code)
                8'h45: ch = 8'h30;  8'h16: ch = 8'h31;  8'h1E: ch = 8'h32;
                8'h26: ch = 8'h33;  8'h25: ch = 8'h34;  8'h2E: ch = 8'h35;
                8'h36: ch = 8'h36;  8'h3D: ch = 8'h37;  8'h3E: ch = 8'h38;
                8'h46: ch = 8'h39;
                SC_SPACE: ch = ASCII_SPACE;
                SC_BKSP:  ch = ASCII_DEL;
                SC_ENTER: ch = ASCII_ENTER;
                default:  hit = 1'b0;
            endcase
        end
        if (is_letter && upper) begin
            ch = ch - 8'h20;
        end
        return {hit, ch};
    endfunction

endpackage
`default_nettype wire

// File: rtl/char_fifo.sv
`default_nettype none
// ============================================================================
// Module      : char_fifo
// Description : First-word-fall-through byte FIFO. dout shows the oldest
//               entry whenever empty=0 (8'h00 when empty). A push while full
//               is accepted only if a pop happens on the same edge.
// Ports       : clock, resetn (async active-low)
//               push/din  - write request and data
//               pop       - remove head (ignored when empty)
//               dout      - head entry
//               empty/full- occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module char_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    logic w_do_pop;
    logic w_do_push;

    assign empty = (r_count == '0);
    assign full  = (r_count == (AW+1)'(DEPTH));

    assign w_do_pop  = pop & ~empty;
    // When full, the slot under the write pointer is the head being popped,
    // so a simultaneous push can reuse it.
    assign w_do_push = push & (~full | w_do_pop);

    assign dout = empty ? 8'h00 : r_mem[r_rptr];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= din;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_ascii_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ps2_ascii_decoder
// Description : Converts a PS/2 set-2 scan-code byte stream into ASCII
//               characters for key presses. Tracks F0 (break) and E0
//               (extended) prefixes plus left/right shift, and queues
//               characters in a small FWFT FIFO with valid/ready handshake.
// Ports       : clock, resetn (async active-low)
//               ps2_key_pressed/ps2_key_data - one strobe per scan byte
//               char_valid/char_ready/char_data - character output handshake
//               shift_active - either shift key held
//               overflow     - sticky, a character was dropped (FIFO full)
//               caps_lock    - caps flag (only with PS2_CAPSLOCK_EN)
// Options     : define PS2_CAPSLOCK_EN to enable caps-lock handling and the
//               caps_lock output.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_ascii_decoder
    import ps2_codes_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       ps2_key_pressed,
    input  logic [7:0] ps2_key_data,
    input  logic       char_ready,
    output logic       char_valid,
    output logic [7:0] char_data,
    output logic       shift_active,
    output logic       overflow
`ifdef PS2_CAPSLOCK_EN
    ,
    output logic       caps_lock
`endif
);

    ps2_state_e r_state;
    ps2_state_e w_state_next;
    logic       r_lshift;
    logic       r_rshift;
    logic       w_lshift_next;
    logic       w_rshift_next;
    logic       r_overflow;

    logic       w_push;
    logic [7:0] w_char;
    logic [8:0] w_map;
    logic       w_upper;
    logic       w_empty;
    logic       w_full;

`ifdef PS2_CAPSLOCK_EN
    logic r_caps;
    logic r_caps_held;       // suppresses typematic repeats of the caps key
    logic w_caps_next;
    logic w_caps_held_next;
    assign w_upper   = (r_lshift | r_rshift) ^ r_caps;
    assign caps_lock = r_caps;
`else
    assign w_upper   = r_lshift | r_rshift;
`endif

    assign w_map = map_make(ps2_key_data, w_upper);

    // ------------------------------------------------------------------
    // Prefix FSM, shift tracking and character selection
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_lshift_next = r_lshift;
        w_rshift_next = r_rshift;
        w_push        = 1'b0;
        w_char        = 8'h00;
`ifdef PS2_CAPSLOCK_EN
        w_caps_next      = r_caps;
        w_caps_held_next = r_caps_held;
`endif
        if (ps2_key_pressed) begin
            case (r_state)
                IDLE: begin
                    if (ps2_key_data == SC_BREAK) begin
                        w_state_next = BRK;
                    end else if (ps2_key_data == SC_EXT) begin
                        w_state_next = EXT;
                    end else begin
                        case (ps2_key_data)
                            SC_LSHIFT: w_lshift_next = 1'b1;
                            SC_RSHIFT: w_rshift_next = 1'b1;
`ifdef PS2_CAPSLOCK_EN
                            SC_CAPS: begin
                                if (!r_caps_held) begin
                                    w_caps_next      = ~r_caps;
                                    w_caps_held_next = 1'b1;
                                end
                            end
`endif
                            default: begin
                                w_push = w_map[8];
                                w_char = w_map[7:0];
                            end
                        endcase
                    end
                end
                BRK: begin
                    w_state_next = IDLE;
                    case (ps2_key_data)
                        SC_LSHIFT: w_lshift_next = 1'b0;
                        SC_RSHIFT: w_rshift_next = 1'b0;
`ifdef PS2_CAPSLOCK_EN
                        SC_CAPS:   w_caps_held_next = 1'b0;
`endif
                        default: ;
                    endcase
                end
                EXT: begin
                    w_state_next = (ps2_key_data == SC_BREAK) ? EXT_BRK : IDLE;
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_lshift   <= 1'b0;
            r_rshift   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_lshift <= w_lshift_next;
            r_rshift <= w_rshift_next;
            // full implies non-empty, so char_ready alone means a pop happens
            if (w_push && w_full && !char_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef PS2_CAPSLOCK_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_caps      <= 1'b0;
            r_caps_held <= 1'b0;
        end else begin
            r_caps      <= w_caps_next;
            r_caps_held <= w_caps_held_next;
        end
    end
`endif

    assign shift_active = r_lshift | r_rshift;
    assign overflow     = r_overflow;
    assign char_valid   = ~w_empty;

    // ------------------------------------------------------------------
    // Character buffer
    // ------------------------------------------------------------------
    char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_char_fifo (
        .clock  (clock),
        .resetn (resetn),
        .push   (w_push),
        .din    (w_char),
        .pop    (char_ready),
        .dout   (char_data),
        .empty  (w_empty),
        .full   (w_full)
    );

endmodule
`default_nettype wire

// File: tb/tb_ps2_ascii_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_ascii_decoder
// Description : Self-checking bench for ps2_ascii_decoder. Stimulus feeds
//               scan bytes and pushes expected characters into a queue; a
//               negedge monitor pops and compares against the DUT output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_ascii_decoder;

    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       ps2_key_pressed = 1'b0;
    logic [7:0] ps2_key_data = 8'h00;
    logic       char_ready = 1'b0;
    logic       char_valid;
    logic [7:0] char_data;
    logic       shift_active;
    logic       overflow;
`ifdef PS2_CAPSLOCK_EN
    logic       caps_lock;
`endif

    ps2_ascii_decoder #(.FIFO_DEPTH(DEPTH), .FIFO_AW(2)) dut (
        .clock           (clock),
        .resetn          (resetn),
        .ps2_key_pressed (ps2_key_pressed),
        .ps2_key_data    (ps2_key_data),
        .char_ready      (char_ready),
        .char_valid      (char_valid),
        .char_data       (char_data),
        .shift_active    (shift_active),
        .overflow        (overflow)
`ifdef PS2_CAPSLOCK_EN
        ,
        .caps_lock       (caps_lock)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    logic [7:0] exp_q[$];
    logic [7:0] make_map [logic [7:0]];
    bit         is_letter [logic [7:0]];
    bit m_brk, m_ext, m_ext_brk, m_lsh, m_rsh, m_ovf, m_caps, m_caps_held;

    function automatic void init_maps();
        logic [7:0] lc [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,
                                8'h43,8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,
                                8'h15,8'h2D,8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,
                                8'h35,8'h1A};
        logic [7:0] dc [10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,
                                8'h3E,8'h46};
        for (int i = 0; i < 26; i++) begin
            make_map[lc[i]]  = 8'(8'h61 + i);
            is_letter[lc[i]] = 1'b1;
        end
        for (int i = 0; i < 10; i++) make_map[dc[i]] = 8'(8'h30 + i);
        make_map[8'h29] = 8'h20;
        make_map[8'h66] = 8'h7F;
        make_map[8'h5A] = 8'h0D;
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        m_brk = 0; m_ext = 0; m_ext_brk = 0;
        m_lsh = 0; m_rsh = 0; m_ovf = 0; m_caps = 0; m_caps_held = 0;
    endfunction

    // Called after the monitor has handled the cycle whose edge consumes b.
    function automatic void model_byte(logic [7:0] b);
        logic [7:0] c;
        if (m_ext_brk) begin m_ext_brk = 0; return; end
        if (m_ext) begin m_ext = 0; m_ext_brk = (b == 8'hF0); return; end
        if (m_brk) begin
            m_brk = 0;
            if (b == 8'h12) m_lsh = 0;
            if (b == 8'h59) m_rsh = 0;
`ifdef PS2_CAPSLOCK_EN
            if (b == 8'h58) m_caps_held = 0;
`endif
            return;
        end
        if (b == 8'hF0) begin m_brk = 1; return; end
        if (b == 8'hE0) begin m_ext = 1; return; end
        if (b == 8'h12) begin m_lsh = 1; return; end
        if (b == 8'h59) begin m_rsh = 1; return; end
`ifdef PS2_CAPSLOCK_EN
        if (b == 8'h58) begin
            if (!m_caps_held) begin m_caps = !m_caps; m_caps_held = 1; end
            return;
        end
`endif
        if (!make_map.exists(b)) return;
        c = make_map[b];
        if (is_letter.exists(b) && ((m_lsh | m_rsh) ^ m_caps)) c = c - 8'h20;
        if (exp_q.size() < DEPTH) exp_q.push_back(c);
        else m_ovf = 1;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        if (resetn) begin
            checks++;
            if (char_valid !== (exp_q.size() != 0)) begin
                errors++;
                $display("FAIL char_valid: got %b expected %b", char_valid, exp_q.size() != 0);
            end
            if (char_valid && exp_q.size() != 0) begin
                checks++;
                if (char_data !== exp_q[0]) begin
                    errors++;
                    $display("FAIL char_data: got %h expected %h", char_data, exp_q[0]);
                end
                if (char_ready) void'(exp_q.pop_front());
            end
            checks++;
            if (shift_active !== (m_lsh | m_rsh)) begin
                errors++;
                $display("FAIL shift_active: got %b expected %b", shift_active, m_lsh | m_rsh);
            end
            checks++;
            if (overflow !== m_ovf) begin
                errors++;
                $display("FAIL overflow: got %b expected %b", overflow, m_ovf);
            end
`ifdef PS2_CAPSLOCK_EN
            checks++;
            if (caps_lock !== m_caps) begin
                errors++;
                $display("FAIL caps_lock: got %b expected %b", caps_lock, m_caps);
            end
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [7:0] b, input logic rdy);
        @(posedge clock); #1;
        ps2_key_pressed = 1'b1;
        ps2_key_data    = b;
        char_ready      = rdy;
        @(negedge clock); #1;
        model_byte(b);
    endtask

    task automatic idle(input int n, input logic rdy);
        repeat (n) begin
            @(posedge clock); #1;
            ps2_key_pressed = 1'b0;
            char_ready      = rdy;
        end
    endtask

    task automatic check_val(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Asynchronous reset pulse away from the clock edges.
    task automatic async_reset();
        @(posedge clock); #3;
        ps2_key_pressed = 1'b0;
        resetn = 1'b0;
        #1;
        model_reset();
        check_val("async_reset_valid", {7'd0, char_valid}, 8'h00);
        check_val("async_reset_data", char_data, 8'h00);
        #3;
        resetn = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        idle(1, 1'b1);
        while (exp_q.size() != 0 && n < 40) begin
            idle(1, 1'b1);
            n++;
        end
        idle(2, 1'b1);
        check_val("drain_empty", 8'(exp_q.size()), 8'h00);
    endtask

    logic [7:0] pool[$];

    initial begin
        init_maps();
        model_reset();
        #2;
        check_val("reset_valid", {7'd0, char_valid}, 8'h00);
        check_val("reset_data", char_data, 8'h00);
        check_val("reset_shift", {7'd0, shift_active}, 8'h00);
        check_val("reset_overflow", {7'd0, overflow}, 8'h00);
        #10;
        resetn = 1'b1;

        // Make, break: exactly one 'a'
        send(8'h1C, 1); send(8'hF0, 1); send(8'h1C, 1); drain();

        // Shifted letter then unshifted
        send(8'h12, 1); send(8'h1C, 1); send(8'hF0, 1); send(8'h1C, 1);
        send(8'hF0, 1); send(8'h12, 1); send(8'h1C, 1); drain();

        // Extended make/break ignored, then space
        send(8'hE0, 1); send(8'h75, 1); send(8'hE0, 1); send(8'hF0, 1);
        send(8'h75, 1); send(8'h29, 1); drain();

        // Right shift, typematic repeats, specials
        send(8'h59, 1); send(8'h2C, 1); send(8'h2C, 1); send(8'h16, 1);
        send(8'hF0, 1); send(8'h59, 1); send(8'h66, 1); send(8'h5A, 1); drain();

        // Overflow: six digits with consumer stalled
        send(8'h16, 0); send(8'h1E, 0); send(8'h26, 0); send(8'h25, 0);
        send(8'h2E, 0); send(8'h36, 0); idle(2, 0);
        drain();

        // Full FIFO: push and pop on the same edge, no overflow
        async_reset();
        send(8'h1C, 0); send(8'h32, 0); send(8'h21, 0); send(8'h23, 0);
        idle(1, 0);
        send(8'h24, 1); idle(1, 0); drain();

`ifdef PS2_CAPSLOCK_EN
        send(8'h58, 1); send(8'h58, 1); send(8'h1C, 1); send(8'h12, 1);
        send(8'h1C, 1); send(8'hF0, 1); send(8'h12, 1); send(8'hF0, 1);
        send(8'h58, 1); send(8'h58, 1); send(8'h1C, 1); drain();
`endif

        // Reset after F0 with two characters buffered
        send(8'h16, 0); send(8'h1E, 0); send(8'hF0, 0);
        async_reset();
        send(8'h1C, 1); drain();

        // Randomised stream
        for (int i = 0; i < 12; i++) pool.push_back(8'hF0);
        pool.push_back(8'hE0); pool.push_back(8'hE0);
        pool.push_back(8'h12); pool.push_back(8'h12); pool.push_back(8'h59);
        pool.push_back(8'h58); pool.push_back(8'h75); pool.push_back(8'h00);
        pool.push_back(8'h29); pool.push_back(8'h66); pool.push_back(8'h5A);
        pool.push_back(8'h1C); pool.push_back(8'h1A); pool.push_back(8'h4D);
        pool.push_back(8'h35); pool.push_back(8'h43); pool.push_back(8'h45);
        pool.push_back(8'h46); pool.push_back(8'h3D); pool.push_back(8'h2B);
        for (int i = 0; i < 400; i++) begin
            send(pool[$urandom_range(0, pool.size() - 1)], 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle(1, 1'($urandom_range(0, 1)));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
